// File: rtl/piso_load_ctrl_if.sv
// Upstream word handshake for piso_load_ctrl.
//   in_valid : producer has a word on in_data
//   in_ready : consumer holding buffer is empty
//   in_data  : WIDTH-bit word
// master = word producer, slave = piso_load_ctrl.
interface piso_load_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/piso_load_ctrl.sv
// Load/shift sequencer for a WIDTH-bit MSB-first PISO shift register.
// Words arrive over a valid/ready handshake into a one-deep holding buffer,
// are loaded into the PISO (ls=0) and then shifted out (ls=1) while
// ser_valid/ser_first/ser_last flag the bit currently on the PISO output.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset (shared with the PISO)
//   up         : upstream handshake (in_valid/in_ready/in_data)
//   ls         : 0 = PISO loads pdata on next edge, 1 = shift
//   pdata      : holding register contents, drives the PISO parallel input
//   ser_valid  : PISO output carries a word bit this cycle
//   ser_first  : that bit is the MSB
//   ser_last   : that bit is the LSB
//   busy       : not idle, or a word is waiting in the buffer
//   tx_count   : number of words fully serialized, wraps
// All outputs decode registered state only; nothing depends on in_valid.
module piso_load_ctrl #(
    parameter int WIDTH = 4,
    parameter int GAP   = 0,
    parameter int CW    = 8
) (
    input  logic             clk,
    input  logic             rst,
    piso_load_ctrl_if.slave  up,
    output logic             ls,
    output logic [WIDTH-1:0] pdata,
    output logic             ser_valid,
    output logic             ser_first,
    output logic             ser_last,
    output logic             busy,
    output logic [CW-1:0]    tx_count
);
    localparam int unsigned   CNTW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNTW-1:0] LAST = CNTW'(WIDTH - 1);
    // The IDLE cycle in which the next word is loaded is itself a gap
    // cycle, so the GAP state only has to cover GAP-1 cycles. That keeps
    // the ser_valid=0 stretch between two queued words at exactly GAP.
    localparam logic [3:0] GAP_LD = (GAP >= 2) ? 4'(GAP - 2) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

    state_t           state;
    logic             hold_full;
    logic [WIDTH-1:0] hold_reg;
    logic [CNTW-1:0]  cnt;
    logic [3:0]       gap_cnt;
    logic             load_now;
    logic             accept;

    // GAP=0 allows a load in the LSB cycle so words stream back-to-back.
    assign load_now = hold_full &&
                      ((state == S_IDLE) ||
                       ((state == S_SHIFT) && (cnt == LAST) && (GAP == 0)));
    // Uses the registered ready, so a buffer that empties this cycle
    // cannot refill until the next one.
    assign accept   = up.in_valid && !hold_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            hold_full <= 1'b0;
            hold_reg  <= '0;
            cnt       <= '0;
            gap_cnt   <= '0;
            tx_count  <= '0;
        end else begin
            // load_now needs hold_full=1 and accept needs hold_full=0
            if (load_now) begin
                hold_full <= 1'b0;
            end else if (accept) begin
                hold_reg  <= up.in_data;
                hold_full <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (load_now) begin
                        state <= S_SHIFT;
                        cnt   <= '0;
                    end
                end
                S_SHIFT: begin
                    if (cnt != LAST) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        tx_count <= tx_count + 1'b1;
                        if (load_now) begin
                            cnt <= '0;
                        end else if (GAP >= 2) begin
                            state   <= S_GAP;
                            gap_cnt <= GAP_LD;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt == 4'd0) state <= S_IDLE;
                    else                 gap_cnt <= gap_cnt - 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign up.in_ready = !hold_full;
    assign ls          = !load_now;
    assign pdata       = hold_reg;
    assign ser_valid   = (state == S_SHIFT);
    assign ser_first   = ser_valid && (cnt == '0);
    assign ser_last    = ser_valid && (cnt == LAST);
    assign busy        = (state != S_IDLE) || hold_full;
endmodule

// File: tb/tb_piso_load_ctrl.sv
module tb_piso_load_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;

    // A: WIDTH=4, GAP=0, CW=2   B: WIDTH=4, GAP=2, CW=8
    piso_load_ctrl_if #(.WIDTH(4)) ifa ();
    piso_load_ctrl_if #(.WIDTH(4)) ifb ();

    logic       ls_a, sv_a, sf_a, sl_a, busy_a;
    logic [3:0] pd_a;
    logic [1:0] tx_a;
    logic       ls_b, sv_b, sf_b, sl_b, busy_b;
    logic [3:0] pd_b;
    logic [7:0] tx_b;

    piso_load_ctrl #(.WIDTH(4), .GAP(0), .CW(2)) dut_a (
        .clk(clk), .rst(rst_a), .up(ifa.slave), .ls(ls_a), .pdata(pd_a),
        .ser_valid(sv_a), .ser_first(sf_a), .ser_last(sl_a), .busy(busy_a),
        .tx_count(tx_a));

    piso_load_ctrl #(.WIDTH(4), .GAP(2), .CW(8)) dut_b (
        .clk(clk), .rst(rst_b), .up(ifb.slave), .ls(ls_b), .pdata(pd_b),
        .ser_valid(sv_b), .ser_first(sf_b), .ser_last(sl_b), .busy(busy_b),
        .tx_count(tx_b));

    // Reference PISOs, MSB first
    logic [3:0] sr_a, sr_b;
    always @(posedge clk or posedge rst_a)
        if (rst_a)      sr_a <= '0;
        else if (!ls_a) sr_a <= pd_a;
        else            sr_a <= {sr_a[2:0], 1'b0};
    always @(posedge clk or posedge rst_b)
        if (rst_b)      sr_b <= '0;
        else if (!ls_b) sr_b <= pd_b;
        else            sr_b <= {sr_b[2:0], 1'b0};

    logic q_a, q_b;
    assign q_a = sr_a[3];
    assign q_b = sr_b[3];

    // {in_ready, ls, ser_valid, ser_first, ser_last, busy}
    logic [5:0] fa, fb;
    assign fa = {ifa.in_ready, ls_a, sv_a, sf_a, sl_a, busy_a};
    assign fb = {ifb.in_ready, ls_b, sv_b, sf_b, sl_b, busy_b};

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single word through idle A with an empty buffer.
    task automatic a_word(input logic [3:0] w, input logic [1:0] exp_tx);
        logic [1:0] prev;
        prev = exp_tx - 2'd1;
        ifa.in_valid = 1'b1;
        ifa.in_data  = w;
        step();
        ifa.in_valid = 1'b0;
        chk("word_load_flags", fa, 6'b000001);
        chk("word_pdata", pd_a, w);
        step();
        for (int i = 0; i < 4; i++) begin
            chk("word_qout", q_a, w[3-i]);
            chk("word_flags", fa, {1'b1, 1'b1, 1'b1, (i == 0), (i == 3), 1'b1});
            chk("word_tx_during", tx_a, prev);
            step();
        end
        chk("word_tx_after", tx_a, exp_tx);
        chk("word_idle_flags", fa, 6'b110000);
    endtask

    initial begin
        logic [7:0]  bits8;
        logic [11:0] bits12;
        logic [3:0]  wb0, wb1;
        rst_a = 1'b1;
        rst_b = 1'b1;
        ifa.in_valid = 1'b0; ifa.in_data = '0;
        ifb.in_valid = 1'b0; ifb.in_data = '0;
        step();
        step();
        chk("rst_a_flags", fa, 6'b110000);
        chk("rst_a_pdata", pd_a, 0);
        chk("rst_a_tx", tx_a, 0);
        chk("rst_b_flags", fb, 6'b110000);
        chk("rst_b_tx", tx_b, 0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        step();
        chk("post_rst_a_flags", fa, 6'b110000);

        // Single word 4'hA
        a_word(4'hA, 2'd1);

        // Back-to-back 4'hC, 4'h3 with GAP=0
        bits8 = 8'hC3;
        ifa.in_valid = 1'b1; ifa.in_data = 4'hC;
        step();                                   // first word loading
        chk("b2b_load1_flags", fa, 6'b000001);
        ifa.in_data = 4'h3;                       // ignored while not ready
        step();
        for (int k = 0; k < 8; k++) begin
            if (k == 1) ifa.in_valid = 1'b0;
            chk("b2b_qout", q_a, bits8[7-k]);
            chk("b2b_flags", fa, {(k == 0 || k >= 4), (k != 3), 1'b1,
                                  (k == 0 || k == 4), (k == 3 || k == 7), 1'b1});
            if (k == 2) chk("b2b_pdata", pd_a, 4'h3);
            if (k == 4) chk("b2b_tx_mid", tx_a, 2'd2);
            step();
        end
        chk("b2b_tx_end", tx_a, 2'd3);
        chk("b2b_idle", fa, 6'b110000);

        // Reset at cnt=2 with a second word buffered
        ifa.in_valid = 1'b1; ifa.in_data = 4'h9;
        step();
        ifa.in_valid = 1'b0;
        step();                                   // cnt0
        ifa.in_valid = 1'b1; ifa.in_data = 4'h5;
        step();                                   // cnt1, 5 buffered
        ifa.in_valid = 1'b0; ifa.in_data = 4'h0;
        step();                                   // cnt2
        chk("mid_flags", fa, 6'b011001);
        chk("mid_qout", q_a, 1'b0);
        #1 rst_a = 1'b1;
        #1;
        chk("rst_mid_flags", fa, 6'b110000);
        chk("rst_mid_pdata", pd_a, 0);
        chk("rst_mid_tx", tx_a, 0);
        chk("rst_mid_qout", q_a, 0);
        step();
        rst_a = 1'b0;
        step();
        chk("rst_rel_flags", fa, 6'b110000);
        step();
        chk("rst_rel_flags2", fa, 6'b110000);
        a_word(4'h6, 2'd1);

        // in_valid held for three words; tx_count wraps (CW=2)
        bits12 = 12'hB4D;
        for (int c = 0; c < 15; c++) begin
            ifa.in_valid = (c <= 6);
            ifa.in_data  = (c < 1) ? 4'hB : (c < 3) ? 4'h4 : 4'hD;
            chk("hold_ready", ifa.in_ready, (c == 0 || c == 2 || c == 6 || c >= 10));
            chk("hold_ls", ls_a, !(c == 1 || c == 5 || c == 9));
            chk("hold_sv", sv_a, (c >= 2 && c <= 13));
            chk("hold_first", sf_a, (c == 2 || c == 6 || c == 10));
            chk("hold_last", sl_a, (c == 5 || c == 9 || c == 13));
            if (c >= 2 && c <= 13) chk("hold_qout", q_a, bits12[13-c]);
            if (c == 3) chk("hold_pdata", pd_a, 4'h4);
            chk("hold_tx", tx_a, (c < 6) ? 2'd1 : (c < 10) ? 2'd2 : (c < 14) ? 2'd3 : 2'd0);
            step();
        end
        ifa.in_valid = 1'b0;
        a_word(4'h2, 2'd1);

        // GAP=2: two queued words
        wb0 = 4'h5;
        wb1 = 4'hE;
        for (int c = 0; c < 14; c++) begin
            ifb.in_valid = (c == 0 || c == 2);
            ifb.in_data  = (c < 2) ? wb0 : wb1;
            chk("gap_ready", ifb.in_ready, (c == 0 || c == 2 || c >= 8));
            chk("gap_ls", ls_b, !(c == 1 || c == 7));
            chk("gap_sv", sv_b, ((c >= 2 && c <= 5) || (c >= 8 && c <= 11)));
            chk("gap_first", sf_b, (c == 2 || c == 8));
            chk("gap_last", sl_b, (c == 5 || c == 11));
            chk("gap_busy", busy_b, (c >= 1 && c <= 12));
            if (c >= 2 && c <= 5)  chk("gap_qout0", q_b, wb0[5-c]);
            if (c >= 8 && c <= 11) chk("gap_qout1", q_b, wb1[11-c]);
            if (c == 3) chk("gap_pdata", pd_b, wb1);
            chk("gap_tx", tx_b, (c < 6) ? 8'd0 : (c < 12) ? 8'd1 : 8'd2);
            step();
        end
        ifb.in_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
